// File: rtl/k_rarb_t1_if.sv
// rtl/k_rarb_t1_if.sv - read-port arbiter bundle: consumer requests, FIFO empty flag, grant/pop strobes
interface k_rarb_t1_if #(
    parameter int n_req = 4,
    parameter int idx_w = 2
);
    logic [n_req-1:0] req;
    logic             rempty;
    logic             rget;
    logic [n_req-1:0] gnt;
    logic [n_req-1:0] pop;
    logic [idx_w-1:0] owner;
    logic             busy;

    modport master (
        input  req,
        input  rempty,
        output rget,
        output gnt,
        output pop,
        output owner,
        output busy
    );

    modport slave (
        output req,
        output rempty,
        input  rget,
        input  gnt,
        input  pop,
        input  owner,
        input  busy
    );
endinterface

// File: rtl/k_rarb_t1.sv
// rtl/k_rarb_t1.sv - round-robin burst arbiter sharing the async FIFO read port among consumers
module k_rarb_t1 #(
    parameter int n_req     = 4,
    parameter int burst_len = 4,
    parameter int idx_w     = 2
) (
    input  logic        rclk,
    input  logic        rrst_n,
    k_rarb_t1_if.master bus
);
    localparam int cnt_w = $clog2(burst_len + 1);
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(burst_len - 1);
    localparam logic [n_req-1:0] one_hot0 = n_req'(1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [n_req-1:0] gnt_q;
    logic [idx_w-1:0] owner_q;
    logic             busy_q;
    logic [cnt_w-1:0] cnt;
    logic [idx_w-1:0] pick;
    logic [idx_w-1:0] j;
    logic             found;
    logic             rget_c;

    // owner_q doubles as the round-robin pointer: search starts just above it
    always_comb begin
        pick  = '0;
        found = 1'b0;
        j     = '0;
        for (int i = 1; i <= n_req; i++) begin
            j = idx_w'((int'(owner_q) + i) % n_req);
            if (!found && bus.req[j]) begin
                found = 1'b1;
                pick  = j;
            end
        end
    end

    assign rget_c    = (state == GRANT) & bus.req[owner_q] & ~bus.rempty;
    assign bus.rget  = rget_c;
    assign bus.pop   = gnt_q & {n_req{rget_c}};
    assign bus.gnt   = gnt_q;
    assign bus.owner = owner_q;
    assign bus.busy  = busy_q;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state   <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            cnt     <= '0;
            owner_q <= idx_w'(n_req - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state   <= GRANT;
                        gnt_q   <= one_hot0 << pick;
                        owner_q <= pick;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                GRANT: begin
                    if (rget_c) begin
                        cnt <= cnt + 1'b1;
                    end
                    // an empty FIFO only stalls; the owner dropping req is the way out
                    if (!bus.req[owner_q] || (rget_c && cnt == last_cnt)) begin
                        state  <= IDLE;
                        gnt_q  <= '0;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    gnt_q  <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_k_rarb_t1.sv
// tb/tb_k_rarb_t1.sv - directed scoreboard bench for k_rarb_t1
module tb_k_rarb_t1;
    logic rclk   = 1'b0;
    logic rrst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   fifo_cnt = 0;
    logic last_rget;
    logic [3:0] exp_q[$];
    logic [3:0] exp1_q[$];

    always #5 rclk = ~rclk;

    k_rarb_t1_if #(.n_req(4), .idx_w(2)) bus ();
    k_rarb_t1_if #(.n_req(4), .idx_w(2)) bus1 ();

    k_rarb_t1 #(.n_req(4), .burst_len(4), .idx_w(2)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus)
    );

    k_rarb_t1 #(.n_req(4), .burst_len(1), .idx_w(2)) dut1 (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fifo_write(input int n);
        fifo_cnt += n;
        bus.rempty = (fifo_cnt == 0);
    endtask

    // one clock: sample strobes, score pops, advance the FIFO model
    task automatic cyc();
        logic [3:0] p0;
        logic [3:0] p1;
        logic [3:0] e;
        #1;
        last_rget = bus.rget;
        p0 = bus.pop;
        p1 = bus1.pop;
        if (p0 !== 4'b0) begin
            if (exp_q.size() == 0) chk("sb0_unexpected_pop", 32'(p0), 0);
            else begin
                e = exp_q.pop_front();
                chk("sb0_pop", 32'(p0), 32'(e));
            end
        end
        if (p1 !== 4'b0) begin
            if (exp1_q.size() == 0) chk("sb1_unexpected_pop", 32'(p1), 0);
            else begin
                e = exp1_q.pop_front();
                chk("sb1_pop", 32'(p1), 32'(e));
            end
        end
        @(posedge rclk);
        #1;
        if (last_rget) fifo_cnt--;
        bus.rempty = (fifo_cnt == 0);
        @(negedge rclk);
    endtask

    task automatic do_reset();
        bus.req  = '0;
        bus1.req = '0;
        rrst_n   = 1'b0;
        @(posedge rclk);
        @(negedge rclk);
        rrst_n   = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int ord4[5];
        int ord1[4];
        ord4 = '{0, 1, 2, 3, 0};
        ord1 = '{0, 1, 0, 1};
        bus.req     = '0;
        bus.rempty  = 1'b1;
        bus1.req    = '0;
        bus1.rempty = 1'b0;
        #1 rrst_n = 1'b0;
        repeat (2) @(negedge rclk);

        chk("rst_gnt",   32'(bus.gnt), 0);
        chk("rst_busy",  32'(bus.busy), 0);
        chk("rst_owner", 32'(bus.owner), 3);
        chk("rst_rget",  32'(bus.rget), 0);
        chk("rst_pop",   32'(bus.pop), 0);
        rrst_n = 1'b1;

        // single requester, 10 words: two bursts of 4 with one idle cycle between
        fifo_write(10);
        bus.req = 4'b0001;
        cyc();
        chk("t1_gnt", 32'(bus.gnt), 1);
        repeat (4) exp_q.push_back(4'b0001);
        repeat (4) cyc();
        chk("t1_idle_busy", 32'(bus.busy), 0);
        chk("t1_idle_gnt", 32'(bus.gnt), 0);
        cyc();
        chk("t1_regnt", 32'(bus.gnt), 1);
        repeat (4) exp_q.push_back(4'b0001);
        repeat (4) cyc();
        chk("t1_end_busy", 32'(bus.busy), 0);
        chk("t1_fifo_left", 32'(fifo_cnt), 2);
        chk("t1_sb_empty", 32'(exp_q.size()), 0);

        // all requesting: round-robin 0,1,2,3,0
        do_reset();
        fifo_write(1000);
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("t2_gnt", 32'(bus.gnt), 32'(1 << ord4[k]));
            repeat (4) exp_q.push_back(4'(1 << ord4[k]));
            repeat (4) cyc();
            chk("t2_gap_busy", 32'(bus.busy), 0);
        end
        chk("t2_sb_empty", 32'(exp_q.size()), 0);

        // owner 2 stalled on an empty FIFO, then fed
        do_reset();
        fifo_cnt   = 0;
        bus.rempty = 1'b1;
        bus.req = 4'b0100;
        cyc();
        chk("t3_gnt", 32'(bus.gnt), 4);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t3_stall_gnt", 32'(bus.gnt), 4);
            chk("t3_stall_rget", 32'(last_rget), 0);
        end
        fifo_write(2);
        repeat (2) exp_q.push_back(4'b0100);
        repeat (2) cyc();
        chk("t3_hold_busy", 32'(bus.busy), 1);
        chk("t3_hold_gnt", 32'(bus.gnt), 4);
        cyc();
        chk("t3_empty_rget", 32'(last_rget), 0);
        fifo_write(5);
        repeat (2) exp_q.push_back(4'b0100);
        repeat (2) cyc();
        chk("t3_release", 32'(bus.busy), 0);
        chk("t3_fifo_left", 32'(fifo_cnt), 3);
        chk("t3_sb_empty", 32'(exp_q.size()), 0);

        // owner 1 drops req after two pops; search resumes at 2
        do_reset();
        fifo_write(1000);
        bus.req = 4'b0010;
        cyc();
        chk("t4_gnt", 32'(bus.gnt), 2);
        repeat (2) exp_q.push_back(4'b0010);
        repeat (2) cyc();
        bus.req = 4'b1001;
        cyc();
        chk("t4_drop_rget", 32'(last_rget), 0);
        chk("t4_drop_busy", 32'(bus.busy), 0);
        cyc();
        chk("t4_next_gnt", 32'(bus.gnt), 8);
        chk("t4_next_owner", 32'(bus.owner), 3);
        bus.req = 4'b0000;
        cyc();
        chk("t4_end_busy", 32'(bus.busy), 0);
        chk("t4_sb_empty", 32'(exp_q.size()), 0);

        // asynchronous reset during the third pop
        do_reset();
        bus.req = 4'b0001;
        cyc();
        chk("t5_gnt", 32'(bus.gnt), 1);
        repeat (2) exp_q.push_back(4'b0001);
        repeat (2) cyc();
        #1;
        chk("t5_rget_pre", 32'(bus.rget), 1);
        #1 rrst_n = 1'b0;
        #1;
        chk("t5_rst_gnt", 32'(bus.gnt), 0);
        chk("t5_rst_rget", 32'(bus.rget), 0);
        chk("t5_rst_pop", 32'(bus.pop), 0);
        chk("t5_rst_busy", 32'(bus.busy), 0);
        @(posedge rclk);
        @(negedge rclk);
        chk("t5_rst_owner", 32'(bus.owner), 3);
        bus.req = 4'b1000;
        rrst_n  = 1'b1;
        cyc();
        chk("t5_post_gnt", 32'(bus.gnt), 8);
        bus.req = 4'b0000;
        cyc();
        chk("t5_sb_empty", 32'(exp_q.size()), 0);

        // burst_len 1 instance alternates 0,1 with one pop each
        do_reset();
        bus1.req = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t6_gnt", 32'(bus1.gnt), 32'(1 << ord1[k]));
            exp1_q.push_back(4'(1 << ord1[k]));
            cyc();
            chk("t6_gap_busy", 32'(bus1.busy), 0);
        end
        bus1.req = 4'b0000;
        cyc();
        chk("t6_sb_empty", 32'(exp1_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
